store_align_buffer: RTL and testbench

STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

---
 rtl/store_align_buffer.sv | 116 +++++++++++
 tb/tb_store_align_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_align_buffer.sv
// Store buffer between the M stage and data memory: aligns, lane-replicates and
// strobes each store at enqueue, then issues entries to memory in FIFO order.
module store_align_buffer #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_size,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [31:0]                req_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  output logic                       err_valid,
  output logic [ADDR_W-1:0]          err_addr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshakes: a request transfers on req_valid && req_ready && !flush; a memory
  // beat transfers on mem_valid && mem_ready. Payload is held while not accepted.

  logic [ADDR_W-1:0] q_addr  [DEPTH];
  logic [31:0]       q_wdata [DEPTH];
  logic [3:0]        q_wstrb [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic        misaligned;
  logic        take;
  logic        enq;
  logic        deq;
  logic        err_set;

  always_comb begin
    al_wdata   = req_data;
    al_wstrb   = 4'b0000;
    misaligned = 1'b0;
    case (req_size)
      2'd0: begin
        al_wdata = {4{req_data[7:0]}};
        al_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        al_wdata   = {2{req_data[15:0]}};
        al_wstrb   = req_addr[1] ? 4'b1100 : 4'b0011;
        misaligned = req_addr[0];
      end
      2'd2: begin
        al_wdata   = req_data;
        al_wstrb   = 4'b1111;
        misaligned = (req_addr[1:0] != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign req_ready = (count != CW'(DEPTH));
  assign mem_valid = (count != '0);

  assign take    = req_valid && req_ready && !flush;
  assign enq     = take && !misaligned;
  assign err_set = take && misaligned;
  assign deq     = mem_valid && mem_ready;

  assign mem_addr  = q_addr[rd_ptr];
  assign mem_wdata = q_wdata[rd_ptr];
  assign mem_wstrb = q_wstrb[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      q_addr[wr_ptr]  <= {req_addr[ADDR_W-1:2], 2'b00};
      q_wdata[wr_ptr] <= al_wdata;
      q_wstrb[wr_ptr] <= al_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_valid <= err_set;
      if (err_set) err_addr <= req_addr;
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      if (flush) begin
        // Keep only the head: the slot after it becomes the next write slot,
        // which also equals the advanced read pointer if the head leaves now.
        wr_ptr <= rd_ptr + PW'(mem_valid);
        count  <= (mem_valid && !deq) ? CW'(1) : '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PW'(1);
        case ({enq, deq})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer: alignment lanes, errors, full/wrap,
// flush and reset behaviour, each scenario checked against hand-computed values.
module tb_store_align_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        err_valid;
  logic [31:0] err_addr;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  store_align_buffer #(.ADDR_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
    .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .err_valid(err_valid), .err_addr(err_addr), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_size  = size;
    req_addr  = addr;
    req_data  = data;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_size  = 2'd0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
    total++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b expected 0", mem_valid); else passed++;
    total++; if (err_valid !== 1'b0) $display("FAIL reset_err_valid: got %b expected 0", err_valid); else passed++;
    total++; if (err_addr !== 32'h0) $display("FAIL reset_err_addr: got %h expected 0", err_addr); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready); else passed++;
  endtask

  task automatic test_byte_store();
    mem_ready = 1'b1;
    drive_req(2'd0, 32'h0000_1003, 32'h0000_00A5);
    total++; if (mem_valid !== 1'b0) $display("FAIL sb_no_same_cycle: got %b expected 0", mem_valid); else passed++;
    tick();
    idle_req();
    total++; if (mem_valid !== 1'b1) $display("FAIL sb_mem_valid: got %b expected 1", mem_valid); else passed++;
    total++; if (mem_addr !== 32'h0000_1000) $display("FAIL sb_addr: got %h expected 00001000", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h expected a5a5a5a5", mem_wdata); else passed++;
    total++; if (mem_wstrb !== 4'b1000) $display("FAIL sb_wstrb: got %b expected 1000", mem_wstrb); else passed++;
    tick();
    total++; if (count !== 3'd0) $display("FAIL sb_drained: got %0d expected 0", count); else passed++;
    mem_ready = 1'b0;
  endtask

  task automatic test_half_word();
    drive_req(2'd1, 32'h0000_2002, 32'h1234_BEEF);
    tick();
    drive_req(2'd2, 32'h0000_2004, 32'hCAFE_F00D);
    tick();
    idle_req();
    total++; if (count !== 3'd2) $display("FAIL hw_count: got %0d expected 2", count); else passed++;
    total++; if (mem_addr !== 32'h0000_2000) $display("FAIL hw_beat0_addr: got %h expected 00002000", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'hBEEF_BEEF) $display("FAIL hw_beat0_wdata: got %h expected beefbeef", mem_wdata); else passed++;
    total++; if (mem_wstrb !== 4'b1100) $display("FAIL hw_beat0_wstrb: got %b expected 1100", mem_wstrb); else passed++;
    mem_ready = 1'b1;
    tick();
    total++; if (mem_addr !== 32'h0000_2004) $display("FAIL hw_beat1_addr: got %h expected 00002004", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'hCAFE_F00D) $display("FAIL hw_beat1_wdata: got %h expected cafef00d", mem_wdata); else passed++;
    total++; if (mem_wstrb !== 4'b1111) $display("FAIL hw_beat1_wstrb: got %b expected 1111", mem_wstrb); else passed++;
    tick();
    total++; if (mem_valid !== 1'b0) $display("FAIL hw_drained: got %b expected 0", mem_valid); else passed++;
    mem_ready = 1'b0;
  endtask

  task automatic test_lanes();
    logic [1:0]  sz [4];
    logic [31:0] ad [4];
    logic [31:0] dt [4];
    logic [31:0] ea [4];
    logic [31:0] ew [4];
    logic [3:0]  es [4];
    sz[0] = 2'd0; ad[0] = 32'h10; dt[0] = 32'h1234_5677; ea[0] = 32'h10; ew[0] = 32'h7777_7777; es[0] = 4'b0001;
    sz[1] = 2'd0; ad[1] = 32'h11; dt[1] = 32'h0000_0088; ea[1] = 32'h10; ew[1] = 32'h8888_8888; es[1] = 4'b0010;
    sz[2] = 2'd1; ad[2] = 32'h20; dt[2] = 32'hAAAA_5555; ea[2] = 32'h20; ew[2] = 32'h5555_5555; es[2] = 4'b0011;
    sz[3] = 2'd2; ad[3] = 32'h30; dt[3] = 32'hDEAD_BEEF; ea[3] = 32'h30; ew[3] = 32'hDEAD_BEEF; es[3] = 4'b1111;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_req(sz[i], ad[i], dt[i]);
      tick();
      idle_req();
      total++; if (mem_addr !== ea[i]) $display("FAIL lane%0d_addr: got %h expected %h", i, mem_addr, ea[i]); else passed++;
      total++; if (mem_wdata !== ew[i]) $display("FAIL lane%0d_wdata: got %h expected %h", i, mem_wdata, ew[i]); else passed++;
      total++; if (mem_wstrb !== es[i]) $display("FAIL lane%0d_wstrb: got %b expected %b", i, mem_wstrb, es[i]); else passed++;
      tick();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz [3];
    logic [31:0] ad [3];
    sz[0] = 2'd2; ad[0] = 32'h0000_3002;
    sz[1] = 2'd1; ad[1] = 32'h0000_3001;
    sz[2] = 2'd3; ad[2] = 32'h0000_3000;
    for (int i = 0; i < 3; i++) begin
      drive_req(sz[i], ad[i], 32'h1111_2222);
      tick();
      idle_req();
      total++; if (err_valid !== 1'b1) $display("FAIL err%0d_valid: got %b expected 1", i, err_valid); else passed++;
      total++; if (err_addr !== ad[i]) $display("FAIL err%0d_addr: got %h expected %h", i, err_addr, ad[i]); else passed++;
      total++; if (count !== 3'd0) $display("FAIL err%0d_count: got %0d expected 0", i, count); else passed++;
      tick();
      total++; if (err_valid !== 1'b0) $display("FAIL err%0d_pulse_end: got %b expected 0", i, err_valid); else passed++;
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++) begin
      drive_req(2'd2, 32'h4000 + 32'(i * 4), 32'h1000_0000 + 32'(i));
      tick();
    end
    total++; if (count !== 3'd4) $display("FAIL full_count: got %0d expected 4", count); else passed++;
    total++; if (req_ready !== 1'b0) $display("FAIL full_ready: got %b expected 0", req_ready); else passed++;
    drive_req(2'd2, 32'h0000_4010, 32'h1000_0004);
    tick();
    idle_req();
    total++; if (count !== 3'd4) $display("FAIL full_fifth_dropped: got %0d expected 4", count); else passed++;
    total++; if (mem_addr !== 32'h0000_4000) $display("FAIL full_head_stable: got %h expected 00004000", mem_addr); else passed++;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_addr !== 32'h4000 + 32'(i * 4)) $display("FAIL wrap%0d_addr: got %h expected %h", i, mem_addr, 32'h4000 + 32'(i * 4)); else passed++;
      total++; if (mem_wdata !== 32'h1000_0000 + 32'(i)) $display("FAIL wrap%0d_wdata: got %h expected %h", i, mem_wdata, 32'h1000_0000 + 32'(i)); else passed++;
      tick();
    end
    total++; if (count !== 3'd0) $display("FAIL wrap_drained: got %0d expected 0", count); else passed++;
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(2'd2, 32'h7000 + 32'(i * 4), 32'hB0B0_0000 + 32'(i));
      tick();
      total++; if (count !== 3'd1) $display("FAIL b2b%0d_count: got %0d expected 1", i, count); else passed++;
      total++; if (mem_wdata !== 32'hB0B0_0000 + 32'(i)) $display("FAIL b2b%0d_wdata: got %h expected %h", i, mem_wdata, 32'hB0B0_0000 + 32'(i)); else passed++;
    end
    idle_req();
    tick();
    total++; if (mem_valid !== 1'b0) $display("FAIL b2b_drained: got %b expected 0", mem_valid); else passed++;
    mem_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive_req(2'd2, 32'h5000 + 32'(i * 4), 32'h5A5A_0000 + 32'(i));
      tick();
    end
    total++; if (count !== 3'd3) $display("FAIL flush_pre_count: got %0d expected 3", count); else passed++;
    flush = 1'b1;
    drive_req(2'd2, 32'h0000_6000, 32'h6666_6666);
    tick();
    total++; if (count !== 3'd1) $display("FAIL flush_count: got %0d expected 1", count); else passed++;
    total++; if (mem_addr !== 32'h0000_5000) $display("FAIL flush_head_addr: got %h expected 00005000", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h5A5A_0000) $display("FAIL flush_head_wdata: got %h expected 5a5a0000", mem_wdata); else passed++;
    drive_req(2'd2, 32'h0000_6002, 32'h6666_6666);
    tick();
    total++; if (err_valid !== 1'b0) $display("FAIL flush_err_dropped: got %b expected 0", err_valid); else passed++;
    total++; if (count !== 3'd1) $display("FAIL flush_repeat_count: got %0d expected 1", count); else passed++;
    flush = 1'b0;
    idle_req();
    drive_req(2'd2, 32'h0000_5100, 32'h5100_0001);
    tick();
    idle_req();
    total++; if (count !== 3'd2) $display("FAIL flush_refill_count: got %0d expected 2", count); else passed++;
    flush = 1'b1;
    mem_ready = 1'b1;
    tick();
    flush = 1'b0;
    mem_ready = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL flush_deq_count: got %0d expected 0", count); else passed++;
    drive_req(2'd0, 32'h0000_5202, 32'h0000_00C3);
    tick();
    idle_req();
    total++; if (mem_addr !== 32'h0000_5200) $display("FAIL flush_ptr_addr: got %h expected 00005200", mem_addr); else passed++;
    total++; if (mem_wstrb !== 4'b0100) $display("FAIL flush_ptr_wstrb: got %b expected 0100", mem_wstrb); else passed++;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_pending();
    drive_req(2'd2, 32'h0000_8000, 32'h8000_0000);
    tick();
    drive_req(2'd2, 32'h0000_8004, 32'h8000_0001);
    tick();
    total++; if (count !== 3'd2) $display("FAIL rstp_pre_count: got %0d expected 2", count); else passed++;
    rst = 1'b1;
    flush = 1'b1;
    mem_ready = 1'b1;
    drive_req(2'd2, 32'h0000_8008, 32'h8000_0002);
    tick();
    rst = 1'b0;
    flush = 1'b0;
    mem_ready = 1'b0;
    idle_req();
    total++; if (mem_valid !== 1'b0) $display("FAIL rstp_mem_valid: got %b expected 0", mem_valid); else passed++;
    total++; if (count !== 3'd0) $display("FAIL rstp_count: got %0d expected 0", count); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL rstp_req_ready: got %b expected 1", req_ready); else passed++;
    drive_req(2'd1, 32'h0000_9002, 32'h0000_1357);
    tick();
    idle_req();
    total++; if (mem_wdata !== 32'h1357_1357) $display("FAIL rstp_after_wdata: got %h expected 13571357", mem_wdata); else passed++;
    total++; if (mem_addr !== 32'h0000_9000) $display("FAIL rstp_after_addr: got %h expected 00009000", mem_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_half_word();
    test_lanes();
    test_misaligned();
    test_full_wrap();
    test_back_to_back();
    test_flush();
    test_reset_pending();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
